// File: rtl/ooo_reservation_station_if.sv
// Allocation, issue, wakeup and branch-resolve bundle of the out-of-order reservation station.
// The slave side is the station itself; the master side is the rename/execute environment.
interface ooo_reservation_station_if #(
    parameter int INPUT_PORTS  = 2,
    parameter int OUTPUT_PORTS = 2,
    parameter int SEARCH_PORTS = 4,
    parameter int REGISTERS    = 128,
    parameter int DEPTH        = 8,
    parameter int SRCS         = 3,
    parameter int BR_DEPTH     = 4,
    parameter int PAYLOAD_W    = 64
) ();
    localparam int TAG_W = $clog2(REGISTERS);
    localparam int BID_W = $clog2(BR_DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [INPUT_PORTS-1:0]                 valid_in;
    logic [INPUT_PORTS-1:0]                 ready_out;
    logic [INPUT_PORTS*SRCS*TAG_W-1:0]      src_tag_in;
    logic [INPUT_PORTS*SRCS-1:0]            pending_in;
    logic [INPUT_PORTS*BR_DEPTH-1:0]        brmask_in;
    logic [INPUT_PORTS*PAYLOAD_W-1:0]       payload_in;
    logic [OUTPUT_PORTS-1:0]                valid_out;
    logic [OUTPUT_PORTS-1:0]                ready_in;
    logic [OUTPUT_PORTS*PAYLOAD_W-1:0]      payload_out;
    logic [OUTPUT_PORTS*BR_DEPTH-1:0]       brmask_out;
    logic [SEARCH_PORTS-1:0]                search_valid;
    logic [SEARCH_PORTS*TAG_W-1:0]          search_tags;
    logic                                   branch_resolved;
    logic [BID_W-1:0]                       resolved_id;
    logic                                   flush;
    logic [CW-1:0]                          free_count;

    modport master (
        output valid_in, src_tag_in, pending_in, brmask_in, payload_in, ready_in,
               search_valid, search_tags, branch_resolved, resolved_id, flush,
        input  ready_out, valid_out, payload_out, brmask_out, free_count
    );

    modport slave (
        input  valid_in, src_tag_in, pending_in, brmask_in, payload_in, ready_in,
               search_valid, search_tags, branch_resolved, resolved_id, flush,
        output ready_out, valid_out, payload_out, brmask_out, free_count
    );
endinterface

// File: rtl/ooo_reservation_station.sv
// Out-of-order issue queue: any-slot allocation, tag-broadcast wakeup,
// oldest-first multi-port issue via an age matrix, and branch-mask squash.
module ooo_reservation_station #(
    parameter int INPUT_PORTS  = 2,
    parameter int OUTPUT_PORTS = 2,
    parameter int SEARCH_PORTS = 4,
    parameter int REGISTERS    = 128,
    parameter int DEPTH        = 8,
    parameter int SRCS         = 3,
    parameter int BR_DEPTH     = 4,
    parameter int PAYLOAD_W    = 64
) (
    input logic                      clk,
    input logic                      rst,
    ooo_reservation_station_if.slave io
);
    localparam int TAG_W = $clog2(REGISTERS);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = (INPUT_PORTS > 1) ? $clog2(INPUT_PORTS) : 1;

    typedef logic [SRCS-1:0][TAG_W-1:0] tags_t;

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [CW-1:0]        free_count_q, free_count_d;
    logic [SRCS-1:0]      pending_q [DEPTH];
    logic [SRCS-1:0]      pending_d [DEPTH];
    tags_t                tag_q [DEPTH];
    tags_t                tag_d [DEPTH];
    logic [BR_DEPTH-1:0]  mask_q [DEPTH];
    logic [BR_DEPTH-1:0]  mask_d [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    // age_q[r][c] set means entry r is older than entry c
    logic [DEPTH-1:0]     age_q [DEPTH];
    logic [DEPTH-1:0]     age_d [DEPTH];

    tags_t                in_tag  [INPUT_PORTS];
    logic [SRCS-1:0]      in_pend [INPUT_PORTS];
    logic [BR_DEPTH-1:0]  in_mask [INPUT_PORTS];
    logic [PAYLOAD_W-1:0] in_pay  [INPUT_PORTS];

    logic                     squash;
    logic [BR_DEPTH-1:0]      clr_mask;
    logic [DEPTH-1:0]         kill, rdy, pop, wr_en;
    logic [CW-1:0]            older_cnt [DEPTH];
    logic [IDX_W-1:0]         sel_idx [OUTPUT_PORTS];
    logic [OUTPUT_PORTS-1:0]  sel_vld;
    logic [INPUT_PORTS-1:0]   ready_out, alloc;
    logic [CW-1:0]            arank [INPUT_PORTS];
    logic [CW-1:0]            fidx;
    logic [PW-1:0]            wr_port [DEPTH];
    logic [OUTPUT_PORTS*PAYLOAD_W-1:0] payload_out;
    logic [OUTPUT_PORTS*BR_DEPTH-1:0]  brmask_out;

    function automatic logic tag_hit(input logic [TAG_W-1:0] tag,
                                     input logic [SEARCH_PORTS-1:0] sv,
                                     input logic [SEARCH_PORTS*TAG_W-1:0] st);
        tag_hit = 1'b0;
        for (int k = 0; k < SEARCH_PORTS; k++)
            if (sv[k] && st[k*TAG_W +: TAG_W] == tag) tag_hit = 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < INPUT_PORTS; i++) begin
            in_tag[i]  = io.src_tag_in[i*SRCS*TAG_W +: SRCS*TAG_W];
            in_pend[i] = io.pending_in[i*SRCS +: SRCS];
            in_mask[i] = io.brmask_in[i*BR_DEPTH +: BR_DEPTH];
            in_pay[i]  = io.payload_in[i*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    assign squash = io.branch_resolved & io.flush;

    always_comb begin
        clr_mask = '1;
        if (io.branch_resolved) clr_mask[io.resolved_id] = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            kill[e] = squash & valid_q[e] & mask_q[e][io.resolved_id];
            rdy[e]  = valid_q[e] & ~(|pending_q[e]) & ~kill[e];
        end
    end

    // Rank each ready entry by how many ready entries are older; rank j feeds port j.
    always_comb begin
        sel_vld = '0;
        pop     = '0;
        for (int j = 0; j < OUTPUT_PORTS; j++) sel_idx[j] = '0;
        for (int e = 0; e < DEPTH; e++) begin
            older_cnt[e] = '0;
            for (int f = 0; f < DEPTH; f++)
                if (f != e && rdy[f] && age_q[f][e]) older_cnt[e] = older_cnt[e] + CW'(1);
        end
        for (int j = 0; j < OUTPUT_PORTS; j++)
            for (int e = 0; e < DEPTH; e++)
                if (rdy[e] && older_cnt[e] == CW'(j)) begin
                    sel_vld[j] = 1'b1;
                    sel_idx[j] = IDX_W'(e);
                    if (io.ready_in[j]) pop[e] = 1'b1;
                end
    end

    always_comb begin
        payload_out = '0;
        brmask_out  = '0;
        for (int j = 0; j < OUTPUT_PORTS; j++)
            if (sel_vld[j]) begin
                payload_out[j*PAYLOAD_W +: PAYLOAD_W] = payload_q[sel_idx[j]];
                brmask_out[j*BR_DEPTH +: BR_DEPTH]    = mask_q[sel_idx[j]] & clr_mask;
            end
    end

    assign io.valid_out   = sel_vld;
    assign io.payload_out = payload_out;
    assign io.brmask_out  = brmask_out;
    assign io.ready_out   = ready_out;
    assign io.free_count  = free_count_q;

    // Accepted pushes take the lowest free slots in port order; slots popped this cycle are not reused yet.
    always_comb begin
        ready_out = '0;
        alloc     = '0;
        wr_en     = '0;
        fidx      = '0;
        for (int i = 0; i < INPUT_PORTS; i++) begin
            arank[i]     = '0;
            ready_out[i] = free_count_q > CW'(i);
            alloc[i]     = io.valid_in[i] & ready_out[i] & ~(squash & in_mask[i][io.resolved_id]);
        end
        for (int i = 1; i < INPUT_PORTS; i++) arank[i] = arank[i-1] + CW'(alloc[i-1]);
        for (int e = 0; e < DEPTH; e++) begin
            wr_port[e] = '0;
            if (!valid_q[e]) begin
                for (int i = 0; i < INPUT_PORTS; i++)
                    if (alloc[i] && arank[i] == fidx) begin
                        wr_en[e]   = 1'b1;
                        wr_port[e] = PW'(i);
                    end
                fidx = fidx + CW'(1);
            end
        end
    end

    always_comb begin
        free_count_d = '0;
        for (int e = 0; e < DEPTH; e++) begin
            valid_d[e] = (valid_q[e] & ~pop[e] & ~kill[e]) | wr_en[e];
            if (wr_en[e]) begin
                tag_d[e]     = in_tag[wr_port[e]];
                pending_d[e] = in_pend[wr_port[e]];
                mask_d[e]    = in_mask[wr_port[e]] & clr_mask;
                payload_d[e] = in_pay[wr_port[e]];
            end else begin
                tag_d[e]     = tag_q[e];
                pending_d[e] = pending_q[e];
                mask_d[e]    = mask_q[e] & clr_mask;
                payload_d[e] = payload_q[e];
            end
            for (int s = 0; s < SRCS; s++)
                if (tag_hit(tag_d[e][s], io.search_valid, io.search_tags)) pending_d[e][s] = 1'b0;
            // New entries are younger than everything resident; lower port wins among same-cycle pushes.
            for (int c = 0; c < DEPTH; c++) begin
                if (c == e)                     age_d[e][c] = 1'b0;
                else if (wr_en[e] && wr_en[c])  age_d[e][c] = wr_port[e] < wr_port[c];
                else if (wr_en[c])              age_d[e][c] = 1'b1;
                else if (wr_en[e])              age_d[e][c] = 1'b0;
                else                            age_d[e][c] = age_q[e][c];
            end
            if (!valid_d[e]) free_count_d = free_count_d + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            free_count_q <= CW'(DEPTH);
        end else begin
            valid_q      <= valid_d;
            free_count_q <= free_count_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q     <= tag_d;
        pending_q <= pending_d;
        mask_q    <= mask_d;
        payload_q <= payload_d;
        age_q     <= age_d;
    end
endmodule
